// File: rtl/exu_hazard_ctrl.sv
// Issue-side hazard control: per-register in-flight scoreboard, RAW stall and redirect flush FSM.
// Optional performance counters are built only when EXU_HAZARD_CTRL_PERF_EN is defined.
module exu_hazard_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned SB_CNT_W     = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        id_valid,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_rs1_used,
  input  logic        id_rs2_used,
  input  logic [4:0]  id_rd,
  input  logic        id_R_wen,
  input  logic        exu_ready,
  input  logic        redirect,
  input  logic        wb_fire,
  input  logic [4:0]  wb_rd,
  input  logic        wb_track,
  output logic        issue_ready,
  output logic        issue_track,
  output logic        inst_clear,
  output logic        stall,
  output logic        busy,
  output logic [31:0] perf_stall_cnt,
  output logic [31:0] perf_flush_cnt
);

  localparam int unsigned NUM_REGS = 32;
  localparam int unsigned FCNT_W   = 3;
  localparam logic [SB_CNT_W-1:0] CNT_MAX    = '1;
  localparam logic [FCNT_W-1:0]   FLUSH_LOAD = FCNT_W'(FLUSH_CYCLES - 1);

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_t;

  state_t                r_state;
  logic [FCNT_W-1:0]     r_fcnt;
  logic [SB_CNT_W-1:0]   r_cnt [1:NUM_REGS-1];
  logic [SB_CNT_W-1:0]   w_cnt [0:NUM_REGS-1];
  logic [NUM_REGS-1:0]   w_inc;
  logic [NUM_REGS-1:0]   w_dec;
  logic                  w_issue_fire;
  logic                  w_stall;
  logic                  w_clear;
  logic                  w_busy;
  logic                  w_track;

  // Scoreboard view with x0 forced to zero so any register index can be looked up.
  always_comb begin
    w_cnt[0] = '0;
    for (int i = 1; i < NUM_REGS; i++) begin
      w_cnt[i] = r_cnt[i];
    end
  end

  always_comb begin
    w_busy = 1'b0;
    for (int i = 1; i < NUM_REGS; i++) begin
      w_busy = w_busy | (r_cnt[i] != '0);
    end
  end

  assign w_track = id_R_wen & (id_rd != 5'd0);

  // A full counter on rd also stalls, so an increment can never overflow.
  assign w_stall = id_valid &
                   ((id_rs1_used & (w_cnt[id_rs1] != '0)) |
                    (id_rs2_used & (w_cnt[id_rs2] != '0)) |
                    (w_track & (w_cnt[id_rd] == CNT_MAX)));

  assign w_clear      = redirect | (r_state == ST_FLUSH);
  assign issue_ready  = ~w_stall & ~w_clear;
  assign w_issue_fire = id_valid & issue_ready & exu_ready;

  always_comb begin
    w_inc = '0;
    w_dec = '0;
    for (int i = 1; i < NUM_REGS; i++) begin
      w_inc[i] = w_issue_fire & w_track & (id_rd == 5'(i));
      w_dec[i] = wb_fire & wb_track & (wb_rd == 5'(i));
    end
  end

  // Simultaneous issue and retire to one register cancel; retire at zero holds zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 1; i < NUM_REGS; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      for (int i = 1; i < NUM_REGS; i++) begin
        if (w_inc[i] && !w_dec[i]) begin
          r_cnt[i] <= r_cnt[i] + SB_CNT_W'(1);
        end else if (w_dec[i] && !w_inc[i] && (r_cnt[i] != '0)) begin
          r_cnt[i] <= r_cnt[i] - SB_CNT_W'(1);
        end
      end
    end
  end

  // Flush sequencer: a redirect in either state (re)loads the hold-off count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_RUN;
      r_fcnt  <= '0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (redirect) begin
            r_state <= ST_FLUSH;
            r_fcnt  <= FLUSH_LOAD;
          end
        end
        ST_FLUSH: begin
          if (redirect) begin
            r_fcnt <= FLUSH_LOAD;
          end else if (r_fcnt == '0) begin
            r_state <= ST_RUN;
          end else begin
            r_fcnt <= r_fcnt - FCNT_W'(1);
          end
        end
        default: begin
          r_state <= ST_RUN;
          r_fcnt  <= '0;
        end
      endcase
    end
  end

  assign issue_track = w_track;
  assign inst_clear  = w_clear;
  assign stall       = w_stall;
  assign busy        = w_busy;

`ifdef EXU_HAZARD_CTRL_PERF_EN
  logic [31:0] r_perf_stall;
  logic [31:0] r_perf_flush;

  // Saturating event counters; every redirect is either a RUN->FLUSH entry or a reload.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf_stall <= '0;
      r_perf_flush <= '0;
    end else begin
      if (w_stall && (r_perf_stall != '1)) begin
        r_perf_stall <= r_perf_stall + 32'd1;
      end
      if (redirect && (r_perf_flush != '1)) begin
        r_perf_flush <= r_perf_flush + 32'd1;
      end
    end
  end

  assign perf_stall_cnt = r_perf_stall;
  assign perf_flush_cnt = r_perf_flush;
`else
  assign perf_stall_cnt = 32'd0;
  assign perf_flush_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_exu_hazard_ctrl.sv
// Directed scoreboard bench for exu_hazard_ctrl (default parameters: FLUSH_CYCLES=2, SB_CNT_W=2).
module tb_exu_hazard_ctrl;

`ifdef EXU_HAZARD_CTRL_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid, id_rs1_used, id_rs2_used, id_R_wen;
  logic [4:0]  id_rs1, id_rs2, id_rd, wb_rd;
  logic        exu_ready, redirect, wb_fire, wb_track;
  logic        issue_ready, issue_track, inst_clear, stall, busy;
  logic [31:0] perf_stall_cnt, perf_flush_cnt;

  int checks = 0;
  int errors = 0;
  int m_stall = 0;
  int m_flush = 0;

  logic [4:0] exp_q [$];
  string      tag_q [$];

  always #5 clk = ~clk;

  exu_hazard_ctrl dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .id_valid       (id_valid),
    .id_rs1         (id_rs1),
    .id_rs2         (id_rs2),
    .id_rs1_used    (id_rs1_used),
    .id_rs2_used    (id_rs2_used),
    .id_rd          (id_rd),
    .id_R_wen       (id_R_wen),
    .exu_ready      (exu_ready),
    .redirect       (redirect),
    .wb_fire        (wb_fire),
    .wb_rd          (wb_rd),
    .wb_track       (wb_track),
    .issue_ready    (issue_ready),
    .issue_track    (issue_track),
    .inst_clear     (inst_clear),
    .stall          (stall),
    .busy           (busy),
    .perf_stall_cnt (perf_stall_cnt),
    .perf_flush_cnt (perf_flush_cnt)
  );

  task automatic drv(input logic v, input logic [4:0] rs1, input logic u1,
                     input logic [4:0] rs2, input logic u2,
                     input logic [4:0] rd, input logic wen, input logic redir,
                     input logic wbf, input logic [4:0] wbrd, input logic wbt);
    id_valid = v;   id_rs1 = rs1; id_rs1_used = u1;
    id_rs2 = rs2;   id_rs2_used = u2;
    id_rd = rd;     id_R_wen = wen;
    redirect = redir;
    wb_fire = wbf;  wb_rd = wbrd; wb_track = wbt;
    if (redir) m_flush++;
  endtask

  task automatic idle();
    drv(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
  endtask

  // Expected {issue_ready, issue_track, inst_clear, stall, busy} for the cycle just driven.
  task automatic expect_out(input string tag, input logic r, input logic t,
                            input logic c, input logic s, input logic b);
    exp_q.push_back({r, t, c, s, b});
    tag_q.push_back(tag);
    if (s) m_stall++;
  endtask

  task automatic sample();
    logic [4:0] e;
    logic [4:0] obs;
    string      tg;
    #1;
    obs = {issue_ready, issue_track, inst_clear, stall, busy};
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty: observed %b expected none queued", obs);
    end else begin
      e  = exp_q.pop_front();
      tg = tag_q.pop_front();
      assert (obs === e) else begin
        errors++;
        $error("FAIL %s: observed rdy/trk/clr/stl/bsy=%b expected %b", tg, obs, e);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step(input string tag, input logic r, input logic t,
                      input logic c, input logic s, input logic b);
    expect_out(tag, r, t, c, s, b);
    sample();
    tick();
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] e);
    checks++;
    assert (obs === e) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, e);
    end
  endtask

  task automatic chk_perf(input string tag);
    chk32({tag, "_stall"}, perf_stall_cnt, PERF ? 32'(m_stall) : 32'd0);
    chk32({tag, "_flush"}, perf_flush_cnt, PERF ? 32'(m_flush) : 32'd0);
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: observed no finish expected finish before 20000");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    exu_ready = 1'b1;
    idle();
    m_flush = 0;
    #12;
    expect_out("reset_state", 1, 0, 0, 0, 0);
    sample();
    chk_perf("reset_perf");
    rst_n = 1'b1;
    tick();

    // RAW on x5: stall until the producer retires, released the cycle after the update
    drv(1, 5'd0, 0, 5'd0, 0, 5'd5, 1, 0, 0, 5'd0, 0);  step("issue_rd5", 1, 1, 0, 0, 0);
    drv(1, 5'd5, 1, 5'd0, 0, 5'd6, 1, 0, 0, 5'd0, 0);  step("raw_stall1", 0, 1, 0, 1, 1);
    drv(1, 5'd5, 1, 5'd0, 0, 5'd6, 1, 0, 0, 5'd0, 0);  step("raw_stall2", 0, 1, 0, 1, 1);
    drv(1, 5'd5, 1, 5'd0, 0, 5'd6, 1, 0, 1, 5'd5, 1);  step("raw_wb_cycle", 0, 1, 0, 1, 1);
    drv(1, 5'd5, 1, 5'd0, 0, 5'd6, 1, 0, 0, 5'd0, 0);  step("raw_released", 1, 1, 0, 0, 0);
    drv(0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 1, 5'd6, 1);  step("retire_rd6", 1, 0, 0, 0, 1);
    idle();                                             step("idle_empty", 1, 0, 0, 0, 0);

    // No issue while EXU is not ready
    exu_ready = 1'b0;
    drv(1, 5'd0, 0, 5'd0, 0, 5'd10, 1, 0, 0, 5'd0, 0); step("exu_not_ready", 1, 1, 0, 0, 0);
    exu_ready = 1'b1;
    idle();                                             step("no_issue_count", 1, 0, 0, 0, 0);

    // Same-cycle issue and retire on x7 leaves count at 1
    drv(1, 5'd0, 0, 5'd0, 0, 5'd7, 1, 0, 0, 5'd0, 0);  step("issue_rd7", 1, 1, 0, 0, 0);
    drv(1, 5'd0, 0, 5'd0, 0, 5'd7, 1, 0, 1, 5'd7, 1);  step("inc_dec_same", 1, 1, 0, 0, 1);
    drv(1, 5'd0, 0, 5'd7, 1, 5'd0, 0, 0, 1, 5'd7, 1);  step("rs2_hold", 0, 0, 0, 1, 1);
    idle();                                             step("rd7_drained", 1, 0, 0, 0, 0);

    // x0 never tracked; x3 saturates at 3 in flight
    drv(1, 5'd0, 0, 5'd0, 0, 5'd0, 1, 0, 0, 5'd0, 0);  step("rd0_untracked", 1, 0, 0, 0, 0);
    idle();                                             step("rd0_not_busy", 1, 0, 0, 0, 0);
    drv(1, 5'd0, 0, 5'd0, 0, 5'd3, 1, 0, 0, 5'd0, 0);  step("rd3_issue1", 1, 1, 0, 0, 0);
    drv(1, 5'd0, 0, 5'd0, 0, 5'd3, 1, 0, 0, 5'd0, 0);  step("rd3_issue2", 1, 1, 0, 0, 1);
    drv(1, 5'd0, 0, 5'd0, 0, 5'd3, 1, 0, 0, 5'd0, 0);  step("rd3_issue3", 1, 1, 0, 0, 1);
    drv(1, 5'd0, 0, 5'd0, 0, 5'd3, 1, 0, 0, 5'd0, 0);  step("rd3_saturated", 0, 1, 0, 1, 1);
    for (int i = 0; i < 3; i++) begin
      drv(0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 1, 5'd3, 1); step("rd3_retire", 1, 0, 0, 0, 1);
    end
    drv(0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 1, 5'd3, 1);  step("dec_at_zero", 1, 0, 0, 0, 0);
    idle();                                             step("no_underflow", 1, 0, 0, 0, 0);

    // Single redirect: clear for 1 + FLUSH_CYCLES cycles
    drv(1, 5'd0, 0, 5'd0, 0, 5'd0, 0, 1, 0, 5'd0, 0);  step("redir_cycle", 0, 0, 1, 0, 0);
    drv(1, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0, 5'd0, 0);  step("flush_1", 0, 0, 1, 0, 0);
    drv(1, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0, 5'd0, 0);  step("flush_2", 0, 0, 1, 0, 0);
    drv(1, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0, 5'd0, 0);  step("flush_done", 1, 0, 0, 0, 0);

    // Second redirect in the 2nd flush cycle reloads the count
    drv(1, 5'd0, 0, 5'd0, 0, 5'd0, 0, 1, 0, 5'd0, 0);  step("rl_redir1", 0, 0, 1, 0, 0);
    drv(1, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0, 5'd0, 0);  step("rl_flush1", 0, 0, 1, 0, 0);
    drv(1, 5'd0, 0, 5'd0, 0, 5'd0, 0, 1, 0, 5'd0, 0);  step("rl_redir2", 0, 0, 1, 0, 0);
    drv(1, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0, 5'd0, 0);  step("rl_ext1", 0, 0, 1, 0, 0);
    drv(1, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0, 5'd0, 0);  step("rl_ext2", 0, 0, 1, 0, 0);
    drv(1, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0, 5'd0, 0);  step("rl_done", 1, 0, 0, 0, 0);

    // Async reset mid-flush with an in-flight write
    drv(1, 5'd0, 0, 5'd0, 0, 5'd9, 1, 0, 0, 5'd0, 0);  step("issue_rd9", 1, 1, 0, 0, 0);
    drv(0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 1, 0, 5'd0, 0);  step("pre_rst_redir", 0, 0, 1, 0, 1);
    idle();
    expect_out("pre_rst_flush", 0, 0, 1, 0, 1);
    sample();
    chk_perf("pre_rst_perf");
    #1;
    rst_n = 1'b0;
    m_stall = 0;
    m_flush = 0;
    expect_out("async_reset", 1, 0, 0, 0, 0);
    sample();
    chk_perf("async_reset_perf");
    tick();
    rst_n = 1'b1;

    // Exactly four stall cycles for the performance counter
    drv(1, 5'd0, 0, 5'd0, 0, 5'd4, 1, 0, 0, 5'd0, 0);  step("issue_rd4", 1, 1, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      drv(1, 5'd4, 1, 5'd0, 0, 5'd0, 0, 0, 0, 5'd0, 0); step("perf_stall", 0, 0, 0, 1, 1);
    end
    drv(0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 1, 5'd4, 1);
    expect_out("retire_rd4", 1, 0, 0, 0, 1);
    sample();
    chk_perf("four_stalls");
    tick();
    idle();                                             step("final_idle", 1, 0, 0, 0, 0);

    checks++;
    assert (exp_q.size() == 0) else begin
      errors++;
      $error("FAIL scoreboard_leftover: observed %0d expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/exu_hazard_ctrl.md
EXU_HAZARD_CTRL -- requirements
Module: exu_hazard_ctrl

Interface
REQ-001 SHALL have parameter FLUSH_CYCLES, default 2, giving the number of cycles inst_clear is held after a redirect (legal range 1..7).
REQ-002 SHALL have parameter SB_CNT_W, default 2, giving the width of each per-register in-flight counter.
REQ-003 SHALL have port clk  input  1  system clock, rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port id_valid  input  1  IDU presents an instruction.
REQ-006 SHALL have ports id_rs1, id_rs2  input  5 each  source register indices.
REQ-007 SHALL have ports id_rs1_used, id_rs2_used  input  1 each  source actually read.
REQ-008 SHALL have port id_rd  input  5  destination index.
REQ-009 SHALL have port id_R_wen  input  1  instruction writes the register file.
REQ-010 SHALL have port exu_ready  input  1  EXU ready_last.
REQ-011 SHALL have port redirect  input  1  taken branch or jump resolved in EXU.
REQ-012 SHALL have port wb_fire  input  1  one instruction retires, including cleared instructions.
REQ-013 SHALL have port wb_rd  input  5  retiring destination index.
REQ-014 SHALL have port wb_track  input  1  retiring instruction was counted at issue.
REQ-015 SHALL have port issue_ready  output  1  IDU may hand over to EXU.
REQ-016 SHALL have port issue_track  output  1  tag carried down the pipe to wb_track.
REQ-017 SHALL have port inst_clear  output  1  squash to EXU/LSU control registers.
REQ-018 SHALL have port stall  output  1  raw-hazard stall indicator.
REQ-019 SHALL have port busy  output  1  any counter nonzero.
REQ-020 SHALL have ports perf_stall_cnt, perf_flush_cnt  output  32 each  performance counters.

Function
REQ-021 SHALL keep a 32-entry scoreboard of SB_CNT_W-bit counters; entry 0 SHALL be hardwired to 0.
REQ-022 SHALL define issue_fire = id_valid & issue_ready & exu_ready.
REQ-023 SHALL set issue_track = id_R_wen & (id_rd != 0), and on issue_fire SHALL increment entry id_rd when issue_track=1.
REQ-024 SHALL, on wb_fire & wb_track, decrement entry wb_rd.
REQ-025 SHALL leave an entry unchanged when its increment and decrement occur in the same cycle.
REQ-026 SHALL drive stall = id_valid & ((id_rs1_used & cnt[id_rs1]!=0) | (id_rs2_used & cnt[id_rs2]!=0) | (issue_track & cnt[id_rd]==max)), combinationally.
REQ-027 SHALL use an FSM with states RUN and FLUSH and a 3-bit flush counter fcnt.
REQ-028 SHALL, in RUN with redirect=1, go to FLUSH with fcnt=FLUSH_CYCLES-1 on the next edge.
REQ-029 SHALL, in FLUSH, decrement fcnt each cycle and return to RUN after fcnt=0; a redirect in FLUSH SHALL reload fcnt=FLUSH_CYCLES-1.
REQ-030 SHALL drive inst_clear = redirect | (state==FLUSH), so inst_clear is high in the redirect cycle and exactly FLUSH_CYCLES further cycles.
REQ-031 SHALL drive issue_ready = ~stall & ~inst_clear, with zero-cycle latency from inputs.
REQ-032 SHALL accept wb_fire in any state; scoreboard decrements SHALL never be suppressed by flush.
REQ-033 SHALL not wrap a counter below 0; a decrement at 0 is a protocol error and SHALL hold 0.
REQ-034 SHALL drive busy = OR of all counters nonzero, registered-free (combinational).

Reset
REQ-035 SHALL, on rst_n low asynchronously, clear all counters, set state=RUN and fcnt=0, and clear both perf counters.
REQ-036 SHALL, after reset, output issue_ready=1 (given id_valid=0 inputs), inst_clear=0, stall=0, busy=0, perf counts 0.
REQ-037 SHALL, on reset asserted mid-FLUSH, drop inst_clear immediately once redirect=0.

Configuration
REQ-038 SHALL, with macro EXU_HAZARD_CTRL_PERF_EN defined, increment perf_stall_cnt each cycle stall=1 and perf_flush_cnt each RUN->FLUSH or FLUSH-reload, both saturating at 0xFFFFFFFF.
REQ-039 SHALL, without EXU_HAZARD_CTRL_PERF_EN, keep the ports and drive both perf outputs constant 0 with no counter flops.

Verification
REQ-040 SHALL cover: issue rd=5 R_wen=1, next cycle id_rs1=5 used -> stall=1, issue_ready=0 until wb_fire wb_rd=5 wb_track=1, then stall=0 the same cycle after the update.
REQ-041 SHALL cover: redirect pulse 1 cycle, FLUSH_CYCLES=2 -> inst_clear high 3 consecutive cycles, issue_ready=0 throughout.
REQ-042 SHALL cover: redirect again in 2nd FLUSH cycle -> inst_clear extends to 3 cycles from the second redirect.
REQ-043 SHALL cover: issue rd=7 and wb_fire wb_rd=7 same cycle with cnt[7]=1 -> cnt[7] stays 1, busy=1.
REQ-044 SHALL cover: rd=0 R_wen=1 issued -> issue_track=0, busy stays 0; three issues to rd=3 with no retire -> 4th with rd=3 stalls.
REQ-045 SHALL cover: rst_n low during FLUSH with pending counters -> busy=0, inst_clear=0 asynchronously; with PERF_EN, 4 stall cycles -> perf_stall_cnt=4.
